hash_table_op_sequencer: RTL and testbench
==========================================

// Module: hash_table_op_sequencer
// PURPOSE
// Multi-cycle successor to the combinational hash-table controller. Accepts one lookup/insert/delete request at a
// time over valid/ready, reads all NUMBER_OF_TABLES ways in parallel and waits READ_LATENCY cycles for the data.
// It then commits writes to one way or to the overflow CAM and returns a registered response over valid/ready.
// Sits between the host request port and the hash-table banks/CAM; tracks CAM occupancy with a correctly sized counter.
// PARAMETERS
// KEY_WIDTH            32  key bits
// DATA_WIDTH           32  payload bits
// NUMBER_OF_TABLES     3   hash ways (>=2)
// HASH_TABLE_MAX_SIZE  8   address bits per way
// CAM_SIZE             16  overflow CAM entries (>=1)
// READ_LATENCY         1   table read latency in cycles (>=1)
// PORTS
// clk                clk  in   1     single clock, rising edge
// reset_n            in   1     asynchronous, active-low reset
// req_valid_i        in   1     request valid
// req_ready_o        out  1     request accepted when valid&ready
// req_op_i           in   2     00 nop, 01 read, 10 write, 11 delete
// req_key_i          in   KEY_WIDTH                    request key
// req_data_i         in   DATA_WIDTH                   write payload
// req_hash_adr_i     in   [NT] x HASH_TABLE_MAX_SIZE   per-way hashed address
// tbl_rd_en_o        out  1     read strobe to all ways
// tbl_adr_o          out  [NT] x HASH_TABLE_MAX_SIZE   per-way address (read and write)
// tbl_rd_key_i       in   [NT] x KEY_WIDTH             per-way read key
// tbl_rd_data_i      in   [NT] x DATA_WIDTH            per-way read data
// tbl_rd_valid_i     in   [NT] x 1                     per-way slot valid flag
// tbl_wr_en_o        out  [NT] x 1                     per-way write strobe
// tbl_wr_valid_o     out  1     valid flag written (1 insert, 0 delete)
// tbl_wr_key_o       out  KEY_WIDTH    key written
// tbl_wr_data_o      out  DATA_WIDTH   data written
// cam_key_o          out  KEY_WIDTH    CAM search/write key (latched request key)
// cam_data_o         out  DATA_WIDTH   CAM write data
// cam_hit_i          in   1     CAM holds cam_key_o (combinational)
// cam_data_i         in   DATA_WIDTH   CAM data on hit
// cam_write_en_o     out  1     CAM insert strobe
// cam_delete_o       out  1     CAM delete strobe
// cam_used_o         out  $clog2(CAM_SIZE+1)   occupied CAM entries
// rsp_valid_o        out  1     response valid
// rsp_ready_i        in   1     response consumed when valid&ready
// rsp_data_o         out  DATA_WIDTH   read data (0 unless read hit)
// rsp_status_o       out  3     000 OK, 001 NOT_FOUND, 010 KEY_PRESENT, 011 NO_SPACE
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0 except req_ready_o=1. cam_used_o=0. The CAM shares reset_n.
// - States: IDLE -> LOOKUP -> COMMIT -> RESP -> IDLE. req_ready_o=1 only in IDLE.
// - IDLE handshake with op!=00: latch op/key/data/addresses and go to LOOKUP. tbl_rd_en_o=1 combinationally on that
//   cycle, with tbl_adr_o=req_hash_adr_i. Op 00 is accepted and dropped: no state change, no response.
// - LOOKUP: hold the latched addresses and count READ_LATENCY cycles, then go to COMMIT.
// - COMMIT (one cycle): hit[i]=tbl_rd_valid_i[i]&(tbl_rd_key_i[i]==key). The lowest hit index wins. Strobes are valid
//   only in this cycle. Response data/status are registered at the end of the cycle.
//   read  : table hit -> data of winning way, OK; else CAM hit -> cam_data_i, OK; else NOT_FOUND.
//   write : any hit or cam_hit_i -> KEY_PRESENT, no strobes. Else the lowest i with !tbl_rd_valid_i[i] gets
//           tbl_wr_en_o[i]=1, tbl_wr_valid_o=1, OK. Else if cam_used_o<CAM_SIZE -> cam_write_en_o, OK. Else NO_SPACE.
//   delete: table hit -> tbl_wr_en_o[winner]=1, tbl_wr_valid_o=0, OK; else CAM hit -> cam_delete_o, OK;
//           else NOT_FOUND.
// - cam_used_o: +1 on cam_write_en_o, -1 on cam_delete_o. Both strobes never fire in the same cycle.
//   The counter never exceeds CAM_SIZE and never wraps below 0 (a delete at 0 still fires but the count holds at 0).
// - RESP: rsp_valid_o=1 and data/status held stable until rsp_ready_i, then go to IDLE. Next accept is possible one
//   cycle later. rsp_valid_o rises READ_LATENCY+2 cycles after accept.
// - reset_n low at any time, including mid-LOOKUP or mid-RESP, aborts the operation. Pending strobes and the
//   response are dropped.
// TESTING
// - Write key 0x5 data 0xAA into empty tables -> tbl_wr_en_o=001, tbl_wr_valid_o=1, status OK, latency READ_LATENCY+2.
// - Write 0x5 again -> status KEY_PRESENT, no strobes. Read 0x5 -> rsp_data_o=0xAA, OK. Read 0x9 -> NOT_FOUND, data 0.
// - Fill all NT ways at one address, then write a new key -> cam_write_en_o pulse, cam_used_o 0->1. Repeat until
//   CAM_SIZE, next write -> NO_SPACE with cam_used_o=CAM_SIZE.
// - Delete a CAM-resident key -> cam_delete_o, cam_used_o decrements. Delete a table key -> tbl_wr_valid_o=0 on
//   the winning way. Delete a missing key -> NOT_FOUND.
// - Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o/data/status stable and req_ready_o=0; release -> IDLE next cycle.
// - Assert reset_n=0 during LOOKUP with READ_LATENCY=3 -> outputs at reset values immediately, no strobes, no response.

Source files
------------

// File: rtl/hash_table_op_sequencer.sv
// Multi-cycle hash-table request sequencer: parallel way read, wait for the read latency,
// commit to one way or the overflow CAM, then hold a registered response until it is consumed.
module hash_table_op_sequencer #(
  parameter int KEY_WIDTH           = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int HASH_TABLE_MAX_SIZE = 8,
  parameter int CAM_SIZE            = 16,
  parameter int READ_LATENCY        = 1
) (
  input  logic                                                    clk,
  input  logic                                                    reset_n,
  input  logic                                                    req_valid_i,
  output logic                                                    req_ready_o,
  input  logic [1:0]                                              req_op_i,
  input  logic [KEY_WIDTH-1:0]                                    req_key_i,
  input  logic [DATA_WIDTH-1:0]                                   req_data_i,
  input  logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]    req_hash_adr_i,
  output logic                                                    tbl_rd_en_o,
  output logic [NUMBER_OF_TABLES-1:0][HASH_TABLE_MAX_SIZE-1:0]    tbl_adr_o,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]              tbl_rd_key_i,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]             tbl_rd_data_i,
  input  logic [NUMBER_OF_TABLES-1:0]                             tbl_rd_valid_i,
  output logic [NUMBER_OF_TABLES-1:0]                             tbl_wr_en_o,
  output logic                                                    tbl_wr_valid_o,
  output logic [KEY_WIDTH-1:0]                                    tbl_wr_key_o,
  output logic [DATA_WIDTH-1:0]                                   tbl_wr_data_o,
  output logic [KEY_WIDTH-1:0]                                    cam_key_o,
  output logic [DATA_WIDTH-1:0]                                   cam_data_o,
  input  logic                                                    cam_hit_i,
  input  logic [DATA_WIDTH-1:0]                                   cam_data_i,
  output logic                                                    cam_write_en_o,
  output logic                                                    cam_delete_o,
  output logic [$clog2(CAM_SIZE+1)-1:0]                           cam_used_o,
  output logic                                                    rsp_valid_o,
  input  logic                                                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                                   rsp_data_o,
  output logic [2:0]                                              rsp_status_o
);

  localparam int NT = NUMBER_OF_TABLES;
  localparam int AW = HASH_TABLE_MAX_SIZE;
  localparam int UW = $clog2(CAM_SIZE + 1);
  localparam int WI = $clog2(NT);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [UW-1:0] CAM_FULL = UW'(CAM_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  localparam logic [2:0] ST_OK          = 3'b000;
  localparam logic [2:0] ST_NOT_FOUND   = 3'b001;
  localparam logic [2:0] ST_KEY_PRESENT = 3'b010;
  localparam logic [2:0] ST_NO_SPACE    = 3'b011;

  typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT, RESP} state_t;

  state_t                     state_reg;
  logic [1:0]                 op_reg;
  logic [KEY_WIDTH-1:0]       key_reg;
  logic [DATA_WIDTH-1:0]      data_reg;
  logic [NT-1:0][AW-1:0]      adr_reg;
  logic [CW-1:0]              cnt_reg;
  logic [UW-1:0]              used_reg;
  logic                       rsp_valid_reg;
  logic [DATA_WIDTH-1:0]      rsp_data_reg;
  logic [2:0]                 rsp_status_reg;

  logic                       accept;
  logic [NT-1:0]              hit;
  logic                       hit_any;
  logic [WI-1:0]              win_idx;
  logic                       free_any;
  logic [WI-1:0]              free_idx;
  logic [NT-1:0]              wr_en_next;
  logic                       wr_valid_next;
  logic                       cam_we_next;
  logic                       cam_del_next;
  logic [DATA_WIDTH-1:0]      data_next;
  logic [2:0]                 status_next;

  assign accept = (state_reg == IDLE) && req_valid_i && (req_op_i != OP_NOP);

  genvar gi;
  generate
    for (gi = 0; gi < NT; gi++) begin : g_way
      assign hit[gi] = tbl_rd_valid_i[gi] && (tbl_rd_key_i[gi] == key_reg);
    end
  endgenerate

  // Scanning downwards leaves the lowest matching index as the winner.
  always_comb begin
    hit_any  = 1'b0;
    win_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        win_idx = WI'(i);
      end
      if (!tbl_rd_valid_i[i]) begin
        free_any = 1'b1;
        free_idx = WI'(i);
      end
    end
  end

  always_comb begin
    wr_en_next    = '0;
    wr_valid_next = 1'b0;
    cam_we_next   = 1'b0;
    cam_del_next  = 1'b0;
    data_next     = '0;
    status_next   = ST_OK;
    if (state_reg == COMMIT) begin
      case (op_reg)
        OP_READ: begin
          if (hit_any)        data_next = tbl_rd_data_i[win_idx];
          else if (cam_hit_i) data_next = cam_data_i;
          else                status_next = ST_NOT_FOUND;
        end
        OP_WRITE: begin
          if (hit_any || cam_hit_i) begin
            status_next = ST_KEY_PRESENT;
          end else if (free_any) begin
            wr_en_next[free_idx] = 1'b1;
            wr_valid_next        = 1'b1;
          end else if (used_reg < CAM_FULL) begin
            cam_we_next = 1'b1;
          end else begin
            status_next = ST_NO_SPACE;
          end
        end
        OP_DELETE: begin
          if (hit_any)        wr_en_next[win_idx] = 1'b1;
          else if (cam_hit_i) cam_del_next = 1'b1;
          else                status_next = ST_NOT_FOUND;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      op_reg         <= OP_NOP;
      key_reg        <= '0;
      data_reg       <= '0;
      adr_reg        <= '0;
      cnt_reg        <= '0;
      used_reg       <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_status_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= req_op_i;
            key_reg   <= req_key_i;
            data_reg  <= req_data_i;
            adr_reg   <= req_hash_adr_i;
            cnt_reg   <= '0;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cnt_reg == CNT_LAST) state_reg <= COMMIT;
          else                     cnt_reg   <= cnt_reg + 1'b1;
        end
        COMMIT: begin
          rsp_valid_reg  <= 1'b1;
          rsp_data_reg   <= data_next;
          rsp_status_reg <= status_next;
          state_reg      <= RESP;
          // Saturate at both ends so a stray strobe can never wrap the count.
          if (cam_we_next && (used_reg != CAM_FULL))  used_reg <= used_reg + 1'b1;
          else if (cam_del_next && (used_reg != '0))  used_reg <= used_reg - 1'b1;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_status_reg <= '0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state_reg == IDLE);
  assign tbl_rd_en_o    = accept;
  assign tbl_adr_o      = accept ? req_hash_adr_i : adr_reg;
  assign tbl_wr_en_o    = wr_en_next;
  assign tbl_wr_valid_o = wr_valid_next;
  assign tbl_wr_key_o   = key_reg;
  assign tbl_wr_data_o  = data_reg;
  assign cam_key_o      = key_reg;
  assign cam_data_o     = data_reg;
  assign cam_write_en_o = cam_we_next;
  assign cam_delete_o   = cam_del_next;
  assign cam_used_o     = used_reg;
  assign rsp_valid_o    = rsp_valid_reg;
  assign rsp_data_o     = rsp_data_reg;
  assign rsp_status_o   = rsp_status_reg;

endmodule

// File: tb/tb_hash_table_op_sequencer.sv
// Bench for hash_table_op_sequencer: table RAM and CAM environment models, a transaction-level
// reference dictionary, and a per-cycle compare process.
module tb_hash_table_op_sequencer;

  localparam int KW    = 32;
  localparam int DW    = 32;
  localparam int NT    = 3;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int CAM   = 4;
  localparam int L     = 3;
  localparam int UW    = $clog2(CAM + 1);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid, req_ready;
  logic [1:0]            req_op;
  logic [KW-1:0]         req_key;
  logic [DW-1:0]         req_data;
  logic [NT-1:0][AW-1:0] req_hash_adr;
  logic                  tbl_rd_en;
  logic [NT-1:0][AW-1:0] tbl_adr;
  logic [NT-1:0][KW-1:0] tbl_rd_key;
  logic [NT-1:0][DW-1:0] tbl_rd_data;
  logic [NT-1:0]         tbl_rd_valid;
  logic [NT-1:0]         tbl_wr_en;
  logic                  tbl_wr_valid;
  logic [KW-1:0]         tbl_wr_key;
  logic [DW-1:0]         tbl_wr_data;
  logic [KW-1:0]         cam_key;
  logic [DW-1:0]         cam_wdata;
  logic                  cam_hit;
  logic [DW-1:0]         cam_rdata;
  logic                  cam_we, cam_del;
  logic [UW-1:0]         cam_used;
  logic                  rsp_valid, rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [2:0]            rsp_status;

  always #5 clk = ~clk;

  hash_table_op_sequencer #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(NT),
    .HASH_TABLE_MAX_SIZE(AW), .CAM_SIZE(CAM), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_key_i(req_key), .req_data_i(req_data), .req_hash_adr_i(req_hash_adr),
    .tbl_rd_en_o(tbl_rd_en), .tbl_adr_o(tbl_adr), .tbl_rd_key_i(tbl_rd_key),
    .tbl_rd_data_i(tbl_rd_data), .tbl_rd_valid_i(tbl_rd_valid),
    .tbl_wr_en_o(tbl_wr_en), .tbl_wr_valid_o(tbl_wr_valid),
    .tbl_wr_key_o(tbl_wr_key), .tbl_wr_data_o(tbl_wr_data),
    .cam_key_o(cam_key), .cam_data_o(cam_wdata), .cam_hit_i(cam_hit),
    .cam_data_i(cam_rdata), .cam_write_en_o(cam_we), .cam_delete_o(cam_del),
    .cam_used_o(cam_used), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_status_o(rsp_status)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table banks: registered read with L cycles of pipeline, contents survive reset_n.
  logic                  tbl_clr;
  logic                  mem_v [NT][DEPTH];
  logic [KW-1:0]         mem_k [NT][DEPTH];
  logic [DW-1:0]         mem_d [NT][DEPTH];
  logic [NT-1:0]         pv [L];
  logic [NT-1:0][KW-1:0] pk [L];
  logic [NT-1:0][DW-1:0] pd [L];

  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      pv[0][i] <= mem_v[i][tbl_adr[i]];
      pk[0][i] <= mem_k[i][tbl_adr[i]];
      pd[0][i] <= mem_d[i][tbl_adr[i]];
    end
    for (int s = 1; s < L; s++) begin
      pv[s] <= pv[s-1];
      pk[s] <= pk[s-1];
      pd[s] <= pd[s-1];
    end
    if (tbl_clr) begin
      for (int i = 0; i < NT; i++)
        for (int j = 0; j < DEPTH; j++) begin
          mem_v[i][j] <= 1'b0;
          mem_k[i][j] <= '0;
          mem_d[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < NT; i++)
        if (tbl_wr_en[i]) begin
          mem_v[i][tbl_adr[i]] <= tbl_wr_valid;
          mem_k[i][tbl_adr[i]] <= tbl_wr_key;
          mem_d[i][tbl_adr[i]] <= tbl_wr_data;
        end
    end
  end
  assign tbl_rd_valid = pv[L-1];
  assign tbl_rd_key   = pk[L-1];
  assign tbl_rd_data  = pd[L-1];

  // Overflow CAM, cleared by reset_n.
  logic          cv [CAM];
  logic [KW-1:0] ck [CAM];
  logic [DW-1:0] cd [CAM];

  always_comb begin
    cam_hit   = 1'b0;
    cam_rdata = '0;
    for (int j = 0; j < CAM; j++)
      if (cv[j] && ck[j] == cam_key) begin
        cam_hit   = 1'b1;
        cam_rdata = cd[j];
      end
  end

  always @(posedge clk or negedge reset_n) begin : cam_upd
    int f;
    if (!reset_n) begin
      for (int j = 0; j < CAM; j++) begin
        cv[j] <= 1'b0;
        ck[j] <= '0;
        cd[j] <= '0;
      end
    end else begin
      f = -1;
      for (int j = CAM - 1; j >= 0; j--) if (!cv[j]) f = j;
      if (cam_we && f >= 0) begin
        cv[f] <= 1'b1;
        ck[f] <= cam_key;
        cd[f] <= cam_wdata;
      end
      if (cam_del)
        for (int j = 0; j < CAM; j++) if (cv[j] && ck[j] == cam_key) cv[j] <= 1'b0;
    end
  end

  // Reference dictionary: what each way and the CAM should hold, independent of the DUT.
  logic          ref_v [NT][DEPTH];
  logic [KW-1:0] ref_k [NT][DEPTH];
  logic [DW-1:0] ref_d [NT][DEPTH];
  logic [KW-1:0] ref_ck [$];
  logic [DW-1:0] ref_cd [$];
  int            ref_used;

  logic [NT-1:0]         exp_wr;
  logic                  exp_wv, exp_cw, exp_cd;
  logic [2:0]            exp_st;
  logic [DW-1:0]         exp_dat;
  logic [KW-1:0]         exp_key;
  logic [DW-1:0]         exp_wdata;
  logic [NT-1:0][AW-1:0] exp_adr;
  int                    exp_used_pre, exp_used_post;
  int                    a_cyc, hold_g;
  logic                  active;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int cam_find(input logic [KW-1:0] key);
    for (int j = 0; j < ref_ck.size(); j++) if (ref_ck[j] == key) return j;
    return -1;
  endfunction

  task automatic model_eval(input logic [1:0] op, input logic [KW-1:0] key,
                            input logic [NT-1:0][AW-1:0] adr);
    int hw, fw, ci;
    hw = -1; fw = -1;
    for (int i = NT - 1; i >= 0; i--) begin
      if (ref_v[i][adr[i]] && ref_k[i][adr[i]] == key) hw = i;
      if (!ref_v[i][adr[i]]) fw = i;
    end
    ci = cam_find(key);
    exp_wr = '0; exp_wv = 0; exp_cw = 0; exp_cd = 0; exp_st = 3'd0; exp_dat = '0;
    exp_used_pre  = ref_used;
    exp_used_post = ref_used;
    case (op)
      2'b01: if (hw >= 0) exp_dat = ref_d[hw][adr[hw]];
             else if (ci >= 0) exp_dat = ref_cd[ci];
             else exp_st = 3'd1;
      2'b10: if (hw >= 0 || ci >= 0) exp_st = 3'd2;
             else if (fw >= 0) begin exp_wr[fw] = 1'b1; exp_wv = 1'b1; end
             else if (ref_used < CAM) begin exp_cw = 1'b1; exp_used_post = ref_used + 1; end
             else exp_st = 3'd3;
      2'b11: if (hw >= 0) exp_wr[hw] = 1'b1;
             else if (ci >= 0) begin exp_cd = 1'b1; exp_used_post = ref_used - 1; end
             else exp_st = 3'd1;
      default: ;
    endcase
  endtask

  task automatic model_apply(input logic [KW-1:0] key, input logic [DW-1:0] data,
                             input logic [NT-1:0][AW-1:0] adr);
    int ci;
    for (int i = 0; i < NT; i++)
      if (exp_wr[i]) begin
        ref_v[i][adr[i]] = exp_wv;
        ref_k[i][adr[i]] = key;
        ref_d[i][adr[i]] = data;
      end
    if (exp_cw) begin ref_ck.push_back(key); ref_cd.push_back(data); end
    if (exp_cd) begin
      ci = cam_find(key);
      ref_ck.delete(ci);
      ref_cd.delete(ci);
    end
    ref_used = exp_used_post;
  endtask

  // Per-cycle comparison against the timeline of the operation in flight.
  always @(negedge clk) begin : compare
    logic in_acc, in_commit, in_resp, busy;
    if (!reset_n) begin
      chk("rst_ctrl", {req_ready, tbl_rd_en, tbl_wr_en, tbl_wr_valid, cam_we, cam_del, rsp_valid},
          {1'b1, 8'b0});
      chk("rst_used", cam_used, 0);
      chk("rst_rsp", {rsp_data, rsp_status}, 0);
      chk("rst_regs", {cam_key, tbl_wr_data}, 0);
      chk("rst_adr", tbl_adr, 0);
    end else begin
      in_acc    = active && cyc == a_cyc;
      in_commit = active && cyc == a_cyc + L + 1;
      in_resp   = active && cyc >= a_cyc + L + 2 && cyc <= a_cyc + L + 2 + hold_g;
      busy      = active && cyc > a_cyc && cyc <= a_cyc + L + 2 + hold_g;
      chk("req_ready", req_ready, !busy);
      chk("rd_en", tbl_rd_en, in_acc);
      if (in_acc) chk("rd_adr", tbl_adr, exp_adr);
      chk("strobes", {tbl_wr_en, cam_we, cam_del}, in_commit ? {exp_wr, exp_cw, exp_cd} : 5'b0);
      if (in_commit && exp_wr != 0) begin
        chk("wr_valid", tbl_wr_valid, exp_wv);
        chk("wr_key", tbl_wr_key, exp_key);
        chk("wr_adr", tbl_adr, exp_adr);
        if (exp_wv) chk("wr_data", tbl_wr_data, exp_wdata);
      end
      if (in_commit && (exp_cw || exp_cd)) chk("cam_key", cam_key, exp_key);
      if (in_commit && exp_cw) chk("cam_wdata", cam_wdata, exp_wdata);
      chk("rsp_valid", rsp_valid, in_resp);
      if (in_resp) chk("rsp", {rsp_status, rsp_data}, {exp_st, exp_dat});
      chk("cam_used", cam_used,
          (active && cyc >= a_cyc + L + 2) ? exp_used_post[UW-1:0] : exp_used_pre[UW-1:0]);
    end
  end

  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] data,
                       input logic [AW-1:0] a0, a1, a2, input logic [2:0] lit_st,
                       input logic [DW-1:0] lit_dat, input logic [NT-1:0] lit_wr,
                       input logic [UW-1:0] lit_used, input int hold);
    logic [NT-1:0][AW-1:0] adr;
    adr = {a2, a1, a0};
    @(posedge clk); #1;
    model_eval(op, key, adr);
    chk("model_status", exp_st, lit_st);
    chk("model_data", exp_dat, lit_dat);
    chk("model_wr", exp_wr, lit_wr);
    exp_key = key; exp_wdata = data; exp_adr = adr;
    a_cyc = cyc; hold_g = hold; active = 1'b1;
    req_valid = 1'b1; req_op = op; req_key = key; req_data = data; req_hash_adr = adr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (L + 1 + hold) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    model_apply(key, data, adr);
    chk("cam_used_after", cam_used, lit_used);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; tbl_clr = 1'b1; active = 1'b0;
    req_valid = 0; req_op = 0; req_key = 0; req_data = 0; req_hash_adr = '0; rsp_ready = 0;
    a_cyc = 0; hold_g = 0; ref_used = 0; exp_used_pre = 0; exp_used_post = 0;
    exp_wr = 0; exp_wv = 0; exp_cw = 0; exp_cd = 0; exp_st = 0; exp_dat = 0;
    exp_key = 0; exp_wdata = 0; exp_adr = '0;
    for (int i = 0; i < NT; i++)
      for (int j = 0; j < DEPTH; j++) begin ref_v[i][j] = 0; ref_k[i][j] = 0; ref_d[i][j] = 0; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1; tbl_clr = 1'b0;

    //     op     key    data     adr0..2  status dat     wr     used hold
    do_op(2'b10, 32'h5,  32'hAA,   1, 2, 3, 3'd0, 32'h0,  3'b001, 0, 0);
    do_op(2'b10, 32'h5,  32'hBB,   1, 2, 3, 3'd2, 32'h0,  3'b000, 0, 0);
    do_op(2'b01, 32'h5,  32'h0,    1, 2, 3, 3'd0, 32'hAA, 3'b000, 0, 0);
    do_op(2'b01, 32'h9,  32'h0,    4, 4, 4, 3'd1, 32'h0,  3'b000, 0, 0);
    do_op(2'b10, 32'h10, 32'h1010, 1, 2, 3, 3'd0, 32'h0,  3'b010, 0, 0);
    do_op(2'b10, 32'h11, 32'h1111, 1, 2, 3, 3'd0, 32'h0,  3'b100, 0, 0);
    do_op(2'b10, 32'h20, 32'h2020, 1, 2, 3, 3'd0, 32'h0,  3'b000, 1, 0);
    do_op(2'b10, 32'h21, 32'h2121, 1, 2, 3, 3'd0, 32'h0,  3'b000, 2, 0);
    do_op(2'b10, 32'h22, 32'h2222, 1, 2, 3, 3'd0, 32'h0,  3'b000, 3, 0);
    do_op(2'b10, 32'h23, 32'h2323, 1, 2, 3, 3'd0, 32'h0,  3'b000, 4, 0);
    do_op(2'b10, 32'h24, 32'h2424, 1, 2, 3, 3'd3, 32'h0,  3'b000, 4, 0);
    do_op(2'b01, 32'h22, 32'h0,    1, 2, 3, 3'd0, 32'h2222, 3'b000, 4, 0);
    do_op(2'b11, 32'h21, 32'h0,    1, 2, 3, 3'd0, 32'h0,  3'b000, 3, 0);
    do_op(2'b11, 32'h10, 32'h0,    1, 2, 3, 3'd0, 32'h0,  3'b010, 3, 0);
    do_op(2'b11, 32'h77, 32'h0,    5, 5, 5, 3'd1, 32'h0,  3'b000, 3, 0);
    do_op(2'b01, 32'h10, 32'h0,    1, 2, 3, 3'd1, 32'h0,  3'b000, 3, 0);
    do_op(2'b10, 32'h30, 32'h3030, 1, 2, 3, 3'd0, 32'h0,  3'b010, 3, 0);
    do_op(2'b01, 32'h30, 32'h0,    1, 2, 3, 3'd0, 32'h3030, 3'b000, 3, 0);
    do_op(2'b01, 32'h5,  32'h0,    1, 2, 3, 3'd0, 32'hAA, 3'b000, 3, 5);

    // A nop is taken and dropped without leaving IDLE.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b00; req_key = 32'h5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("nop_ready", req_ready, 1'b1);

    do_op(2'b10, 32'h24, 32'h2424, 1, 2, 3, 3'd0, 32'h0,  3'b000, 4, 0);

    // Abort a write in the middle of LOOKUP.
    @(posedge clk); #1;
    model_eval(2'b10, 32'h40, {4'd6, 4'd6, 4'd6});
    exp_key = 32'h40; exp_wdata = 32'h4040; exp_adr = {4'd6, 4'd6, 4'd6};
    a_cyc = cyc; hold_g = 0; active = 1'b1;
    req_valid = 1'b1; req_op = 2'b10; req_key = 32'h40; req_data = 32'h4040;
    req_hash_adr = {4'd6, 4'd6, 4'd6};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0; active = 1'b0;
    #1;
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_used", cam_used, 0);
    chk("abort_rsp", rsp_valid, 1'b0);
    ref_ck.delete(); ref_cd.delete(); ref_used = 0; exp_used_pre = 0; exp_used_post = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (L + 4) @(posedge clk);
    #1;

    do_op(2'b01, 32'h40, 32'h0,    6, 6, 6, 3'd1, 32'h0,  3'b000, 0, 0);
    do_op(2'b01, 32'h22, 32'h0,    1, 2, 3, 3'd1, 32'h0,  3'b000, 0, 0);
    do_op(2'b01, 32'h5,  32'h0,    1, 2, 3, 3'd0, 32'hAA, 3'b000, 0, 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
